hs_mem_target: RTL and testbench

Target-side bridge for the CPU's 3-phase handshake memory bus: address low, address high, data. It decodes the multiplexed 8-bit bus, drives a synchronous single-port SRAM interface and returns the acknowledge. It sits directly downstream of the CPU's bus master, on the other side of its `uio`/handshake pins, in the FPGA/bench companion build.

---
 rtl/hs_bus_pkg.sv | 26 ++
 rtl/hs_mem_target_sync2.sv | 28 ++
 rtl/hs_mem_target.sv | 180 ++++++++++++++++++
 tb/tb_hs_mem_target.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_bus_pkg.sv
// hs_bus_pkg: shared types and constants for the 3-phase handshake memory bus.
//   - phase_t / PH_*   : bus phase encoding (address low, address high, data)
//   - state_t          : target FSM states
//   - bus_byte_t       : one byte on the multiplexed bus
//   - next_phase()     : phase sequencing 0 -> 1 -> 2 -> 0
package hs_bus_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_ADDR_LO = 2'd0;
  localparam phase_t PH_ADDR_HI = 2'd1;
  localparam phase_t PH_DATA    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RDWAIT = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  typedef logic [7:0] bus_byte_t;

  function automatic phase_t next_phase(input phase_t p);
    return (p == PH_DATA) ? PH_ADDR_LO : phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/hs_mem_target_sync2.sv
// sync2: two-flop synchroniser for a single-bit level, reset to 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input level
//   q          : synchronised level, two clk cycles behind d
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is written with non-blocking assignments so both
  // flops sample their inputs from before the edge; blocking here would
  // collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hs_mem_target.sv
// hs_mem_target: target-side bridge for the 3-phase handshake memory bus.
// Decodes address-low / address-high / data phases from the multiplexed byte
// bus, drives a synchronous single-port SRAM and returns the acknowledge.
//
// Build option: define HS_TARGET_SYNC_EN to pass hs_req/hs_rd/hs_wr through
// two-flop synchronisers (adds 2 cycles to every handshake response).
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   hs_req, hs_rd, hs_wr: master request and read/write strobes
//   hs_ack              : acknowledge to the master
//   bus_in              : address / write data byte from the master
//   bus_out, bus_oe     : read data byte and its all-or-nothing drive enable
//   mem_addr, mem_wdata : SRAM address and write data
//   mem_we, mem_re      : one-cycle SRAM write / read strobes
//   mem_rdata           : SRAM read data
//   phase               : current bus phase (0 addr lo, 1 addr hi, 2 data)
//   sync_err            : one-cycle pulse on protocol resynchronisation
module hs_mem_target
  import hs_bus_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hs_req,
  input  logic              hs_rd,
  input  logic              hs_wr,
  output logic              hs_ack,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_out,
  output logic [7:0]        bus_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        phase,
  output logic              sync_err
);

  logic req_s, rd_s, wr_s;

`ifdef HS_TARGET_SYNC_EN
  // bus_in is deliberately not synchronised: the master holds it stable well
  // before the synchronised request rises.
  sync2 u_sync_req (.clk(clk), .rst_n(rst_n), .d(hs_req), .q(req_s));
  sync2 u_sync_rd  (.clk(clk), .rst_n(rst_n), .d(hs_rd),  .q(rd_s));
  sync2 u_sync_wr  (.clk(clk), .rst_n(rst_n), .d(hs_wr),  .q(wr_s));
`else
  assign req_s = hs_req;
  assign rd_s  = hs_rd;
  assign wr_s  = hs_wr;
`endif

  state_t    state, state_nxt;
  phase_t    phase_q, phase_d;
  logic      ack_q, ack_d;
  logic      oe_q, oe_d;
  logic      we_q, we_d;
  logic      re_q, re_d;
  logic      err_q, err_d;
  logic      ld_lo, ld_hi, ld_wd, ld_rd;
  logic [15:0] addr_q;
  bus_byte_t wdata_q, rdata_q;

  // Master abandoned a transaction part-way: no strobes while mid-sequence.
  logic resync, start, start_rd;
  assign resync   = (state == S_IDLE) && (phase_q != PH_ADDR_LO) && !rd_s && !wr_s;
  assign start    = (state == S_IDLE) && req_s && !resync && (rd_s || wr_s);
  assign start_rd = start && (phase_q == PH_DATA) && !wr_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = start_rd ? S_RDWAIT : S_ACK;
      S_RDWAIT: state_nxt = S_ACK;
      S_ACK:    if (!req_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and load enables.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    ack_d   = ack_q;
    oe_d    = oe_q;
    phase_d = phase_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    err_d   = 1'b0;
    ld_lo   = 1'b0;
    ld_hi   = 1'b0;
    ld_wd   = 1'b0;
    ld_rd   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (resync) begin
          phase_d = PH_ADDR_LO;
          err_d   = 1'b1;
        end else if (start) begin
          unique case (phase_q)
            PH_ADDR_LO: begin ld_lo = 1'b1; ack_d = 1'b1; end
            PH_ADDR_HI: begin ld_hi = 1'b1; ack_d = 1'b1; end
            default: begin
              if (wr_s) begin
                // Write wins over a simultaneous read; flag the conflict.
                ld_wd = 1'b1;
                we_d  = 1'b1;
                ack_d = 1'b1;
                err_d = rd_s;
              end else begin
                re_d = 1'b1;
              end
            end
          endcase
        end
      end
      // mem_rdata is taken on the edge that closes the mem_re cycle.
      S_RDWAIT: begin
        ld_rd = 1'b1;
        oe_d  = 1'b1;
        ack_d = 1'b1;
      end
      S_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          oe_d    = 1'b0;
          phase_d = next_phase(phase_q);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= PH_ADDR_LO;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      re_q    <= re_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      if (ld_lo) addr_q[7:0]  <= bus_in;
      if (ld_hi) addr_q[15:8] <= bus_in;
      if (ld_wd) wdata_q      <= bus_in;
      if (ld_rd) rdata_q      <= mem_rdata;
    end
  end

  assign hs_ack    = ack_q;
  assign bus_out   = rdata_q;
  assign bus_oe    = {8{oe_q}};
  assign mem_addr  = addr_q[ADDR_W-1:0];
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign phase     = phase_q;
  assign sync_err  = err_q;

endmodule

// File: tb/tb_hs_mem_target.sv
// tb_hs_mem_target: directed self-checking bench for hs_mem_target.
// Acts as the bus master and as a synchronous SRAM; inputs are driven and
// outputs sampled on the falling edge. Honours HS_TARGET_SYNC_EN.
module tb_hs_mem_target;

`ifdef HS_TARGET_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs_req, hs_rd, hs_wr;
  logic        hs_ack;
  logic [7:0]  bus_in, bus_out, bus_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [1:0]  phase;
  logic        sync_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hs_mem_target #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .hs_req(hs_req), .hs_rd(hs_rd), .hs_wr(hs_wr), .hs_ack(hs_ack),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .phase(phase), .sync_err(sync_err)
  );

  // SRAM model. Unwritten locations read as addr[7:0] ^ 8'hC3.
  // NOTE: the model memory is never reset; 2-state arrays start at zero and
  // the written flag decides what a read returns.
  bit [7:0] mem  [65536];
  bit       seen [65536];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]  <= mem_wdata;
      seen[mem_addr] <= 1'b1;
    end
    mem_rdata <= seen[mem_addr] ? mem[mem_addr] : (mem_addr[7:0] ^ 8'hC3);
  end

  // Pulse monitor: cumulative counts, tests compare snapshots.
  int          we_cnt = 0, re_cnt = 0, err_cnt = 0;
  logic [15:0] we_addr = '0;
  logic [7:0]  we_data = '0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (mem_re)   re_cnt  = re_cnt + 1;
    if (sync_err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One handshake phase, entered and left on a falling edge.
  task automatic phase_xfer(input string tag, input logic [7:0] data,
                            input logic rd, input logic wr, input int exp_rise,
                            output int we_at, output int re_at,
                            output logic [7:0] rbyte, output logic [7:0] roe);
    int n;
    we_at = 0;
    re_at = 0;
    hs_req = 1'b1;
    bus_in = data;
    hs_rd  = rd;
    hs_wr  = wr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_we && we_at == 0) we_at = n;
      if (mem_re && re_at == 0) re_at = n;
    end while (!hs_ack && n < 40);
    check({tag, "_ack_rise"}, n, exp_rise);
    rbyte  = bus_out;
    roe    = bus_oe;
    hs_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (hs_ack && n < 40);
    check({tag, "_ack_fall"}, n, 1 + SYNC);
    check({tag, "_oe_after_fall"}, bus_oe, 8'h00);
  endtask

  task automatic write_txn(input string tag, input logic [15:0] addr,
                           input logic [7:0] data, input logic also_rd);
    int we_at, re_at, w0;
    logic [7:0] rb, ro;
    w0 = we_cnt;
    check({tag, "_ph0"}, phase, 0);
    phase_xfer({tag, "_p0"}, addr[7:0], also_rd, 1'b1, 1 + SYNC, we_at, re_at, rb, ro);
    check({tag, "_ph1"}, phase, 1);
    phase_xfer({tag, "_p1"}, addr[15:8], also_rd, 1'b1, 1 + SYNC, we_at, re_at, rb, ro);
    check({tag, "_ph2"}, phase, 2);
    phase_xfer({tag, "_p2"}, data, also_rd, 1'b1, 1 + SYNC, we_at, re_at, rb, ro);
    check({tag, "_we_at"}, we_at, 1 + SYNC);
    check({tag, "_we_cnt"}, we_cnt - w0, 1);
    check({tag, "_we_addr"}, we_addr, addr);
    check({tag, "_we_data"}, we_data, data);
    check({tag, "_ph_end"}, phase, 0);
  endtask

  task automatic read_txn(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    int we_at, re_at, r0;
    logic [7:0] rb, ro;
    r0 = re_cnt;
    check({tag, "_ph0"}, phase, 0);
    phase_xfer({tag, "_p0"}, addr[7:0], 1'b1, 1'b0, 1 + SYNC, we_at, re_at, rb, ro);
    check({tag, "_ph1"}, phase, 1);
    phase_xfer({tag, "_p1"}, addr[15:8], 1'b1, 1'b0, 1 + SYNC, we_at, re_at, rb, ro);
    check({tag, "_ph2"}, phase, 2);
    phase_xfer({tag, "_p2"}, 8'h00, 1'b1, 1'b0, 2 + SYNC, we_at, re_at, rb, ro);
    check({tag, "_re_at"}, re_at, 1 + SYNC);
    check({tag, "_re_cnt"}, re_cnt - r0, 1);
    check({tag, "_data"}, rb, exp);
    check({tag, "_oe"}, ro, 8'hFF);
    check({tag, "_ph_end"}, phase, 0);
  endtask

  initial begin
    int we_at, re_at, e0, n;
    logic [7:0] rb, ro;

    // NOTE: the bench drives DUT inputs with blocking assignments on the
    // falling edge, well away from the edge the DUT samples on.
    rst_n  = 1'b0;
    hs_req = 1'b0;
    hs_rd  = 1'b0;
    hs_wr  = 1'b0;
    bus_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {hs_ack, bus_oe, bus_out, mem_addr, mem_wdata, mem_we, mem_re, phase, sync_err}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xAB to 0x1234, then read it back.
    write_txn("wr1234", 16'h1234, 8'hAB, 1'b0);
    hs_wr = 1'b0;
    @(negedge clk);
    read_txn("rd1234", 16'h1234, 8'hAB);

    // Back-to-back reads, no idle gap, no resync.
    e0 = err_cnt;
    read_txn("rd0000", 16'h0000, 8'hC3);
    read_txn("rd0001", 16'h0001, 8'hC2);
    check("b2b_no_sync_err", err_cnt - e0, 0);
    hs_rd = 1'b0;
    repeat (2) @(negedge clk);

    // Request with no strobe in phase 0: ignored.
    hs_req = 1'b1;
    repeat (5) @(negedge clk);
    check("nostrobe_ack", hs_ack, 1'b0);
    check("nostrobe_phase", phase, 0);
    hs_req = 1'b0;
    @(negedge clk);

    // Write and read strobes together: write wins, sync_err pulses.
    e0 = err_cnt;
    write_txn("wrboth", 16'h0042, 8'h77, 1'b1);
    check("both_sync_err", err_cnt - e0, 1);
    hs_rd = 1'b0;
    hs_wr = 1'b0;
    @(negedge clk);
    read_txn("rd0042", 16'h0042, 8'h77);
    hs_rd = 1'b0;
    @(negedge clk);

    // Asynchronous reset while acknowledging phase 1.
    phase_xfer("rst_p0", 8'h34, 1'b0, 1'b1, 1 + SYNC, we_at, re_at, rb, ro);
    hs_req = 1'b1;
    bus_in = 8'h12;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hs_ack && n < 40);
    check("rst_in_ack", hs_ack, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          {hs_ack, bus_oe, bus_out, mem_addr, mem_wdata, mem_we, mem_re, phase, sync_err}, 64'd0);
    hs_req = 1'b0;
    hs_wr  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    write_txn("wr00ff", 16'h00FF, 8'h5C, 1'b0);
    hs_wr = 1'b0;
    @(negedge clk);
    read_txn("rd00ff", 16'h00FF, 8'h5C);
    hs_rd = 1'b0;
    @(negedge clk);

    // Resync: master abandons a write after phase 1.
    e0 = err_cnt;
    phase_xfer("rs_p0", 8'h99, 1'b0, 1'b1, 1 + SYNC, we_at, re_at, rb, ro);
    phase_xfer("rs_p1", 8'h88, 1'b0, 1'b1, 1 + SYNC, we_at, re_at, rb, ro);
    check("rs_ph_before", phase, 2);
    hs_wr = 1'b0;
    repeat (4 + SYNC) @(negedge clk);
    check("rs_sync_err", err_cnt - e0, 1);
    check("rs_phase", phase, 0);
    read_txn("rs_rd1234", 16'h1234, 8'hAB);
    hs_rd = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
